// File: rtl/traffic_sensor_conditioner.sv
// Conditions raw highway/farm vehicle detectors into the controller's request vector:
// per channel a 2-flop synchroniser, debouncer, request latch, stuck-high detector and registered output.
module traffic_sensor_conditioner #(
    parameter int unsigned DEB_CYCLES   = 4,
    parameter int unsigned STUCK_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] raw_det,
    input  logic [2:0] light_highway,
    input  logic [2:0] light_farm,
    output logic [1:0] sensor,
    output logic [1:0] stuck
);

    localparam int unsigned NCH    = 2;
    localparam int unsigned CNT_W  = $clog2(DEB_CYCLES);
    localparam int unsigned SCNT_W = $clog2(STUCK_CYCLES + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [SCNT_W-1:0] SCNT_MAX = SCNT_W'(STUCK_CYCLES);

    logic [NCH-1:0]             s1_q, s2_q;
    logic [NCH-1:0]             stb_q, stb_d;
    logic [NCH-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [NCH-1:0]             req_q, req_d;
    logic [NCH-1:0][SCNT_W-1:0] scnt_q, scnt_d;
    logic [NCH-1:0]             stuck_q, stuck_d;
    logic [NCH-1:0]             sensor_q, sensor_d;
    logic [NCH-1:0]             green_c;

    // Only the green lamp bit matters; red/yellow are deliberately ignored.
    assign green_c = {light_highway[0], light_farm[0]};

    logic unused_lamp_bits;
    assign unused_lamp_bits = ^{light_highway[2:1], light_farm[2:1]};

    // Debounce, request latch, stuck detection and output for each channel.
    always_comb begin
        stb_d    = stb_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        scnt_d   = scnt_q;
        stuck_d  = stuck_q;
        sensor_d = sensor_q;

        for (int unsigned i = 0; i < NCH; i++) begin
            if (s2_q[i] != stb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stb_d[i] = s2_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end else begin
                cnt_d[i] = '0;
            end

            // A rise on the same edge as green must win so the new vehicle is not lost.
            req_d[i] = (~stb_q[i] & stb_d[i]) | (req_q[i] & ~green_c[i]);

            if (!stb_q[i]) begin
                scnt_d[i] = '0;
            end else if (scnt_q[i] != SCNT_MAX) begin
                scnt_d[i] = scnt_q[i] + SCNT_W'(1);
            end

            stuck_d[i]  = stuck_q[i] | (scnt_d[i] == SCNT_MAX);
            sensor_d[i] = req_q[i] | stb_q[i] | stuck_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q     <= '0;
            s2_q     <= '0;
            stb_q    <= '0;
            cnt_q    <= '0;
            req_q    <= '0;
            scnt_q   <= '0;
            stuck_q  <= '0;
            sensor_q <= '0;
        end else begin
            s1_q     <= raw_det;
            s2_q     <= s1_q;
            stb_q    <= stb_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            scnt_q   <= scnt_d;
            stuck_q  <= stuck_d;
            sensor_q <= sensor_d;
        end
    end

    assign sensor = sensor_q;
    assign stuck  = stuck_q;

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Directed self-checking bench for traffic_sensor_conditioner (DEB_CYCLES=4, STUCK_CYCLES=16).
module tb_traffic_sensor_conditioner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] raw_det;
    logic [2:0] light_highway;
    logic [2:0] light_farm;
    logic [1:0] sensor;
    logic [1:0] stuck;

    int vectors = 0;
    int errors  = 0;

    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] GREEN = 3'b001;

    traffic_sensor_conditioner #(
        .DEB_CYCLES  (4),
        .STUCK_CYCLES(16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .raw_det      (raw_det),
        .light_highway(light_highway),
        .light_farm   (light_farm),
        .sensor       (sensor),
        .stuck        (stuck)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle; inputs set after this are sampled at the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        raw_det       = 2'b00;
        light_highway = RED;
        light_farm    = RED;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (sensor !== 2'b00) begin errors++; $display("FAIL reset_sensor got=%b exp=%b", sensor, 2'b00); end
        vectors++;
        if (stuck !== 2'b00) begin errors++; $display("FAIL reset_stuck got=%b exp=%b", stuck, 2'b00); end
        // Highway car held: edge k is the next edge, sensor must rise exactly at k+6.
        raw_det = 2'b10;
        for (int j = 1; j <= 7; j++) begin
            tick();
            vectors++;
            if (j < 7 && sensor !== 2'b00) begin
                errors++; $display("FAIL latency_early j=%0d got=%b exp=%b", j, sensor, 2'b00);
            end else if (j == 7 && sensor !== 2'b10) begin
                errors++; $display("FAIL latency_k6 got=%b exp=%b", sensor, 2'b10);
            end
        end
        vectors++;
        if (stuck !== 2'b00) begin errors++; $display("FAIL latency_stuck got=%b exp=%b", stuck, 2'b00); end
    endtask

    task automatic test_glitch();
        do_reset();
        raw_det = 2'b01;
        for (int j = 0; j < 3; j++) tick();
        raw_det = 2'b00;
        for (int j = 0; j < 12; j++) begin
            tick();
            vectors++;
            if (sensor !== 2'b00) begin errors++; $display("FAIL glitch3 j=%0d got=%b exp=%b", j, sensor, 2'b00); end
        end
        // Exactly DEB_CYCLES wide pulse is accepted.
        raw_det = 2'b01;
        for (int j = 1; j <= 7; j++) begin
            tick();
            if (j == 4) raw_det = 2'b00;
            if (j == 6) begin
                vectors++;
                if (sensor !== 2'b00) begin errors++; $display("FAIL pulse4_k5 got=%b exp=%b", sensor, 2'b00); end
            end
            if (j == 7) begin
                vectors++;
                if (sensor !== 2'b01) begin errors++; $display("FAIL pulse4_k6 got=%b exp=%b", sensor, 2'b01); end
            end
        end
    endtask

    task automatic test_req_hold_clear();
        do_reset();
        raw_det = 2'b01;
        for (int j = 0; j < 6; j++) tick();
        raw_det = 2'b00;
        tick();
        vectors++;
        if (sensor !== 2'b01) begin errors++; $display("FAIL hold_rise got=%b exp=%b", sensor, 2'b01); end
        for (int j = 0; j < 12; j++) tick();
        vectors++;
        if (sensor !== 2'b01) begin errors++; $display("FAIL hold_after_leave got=%b exp=%b", sensor, 2'b01); end
        light_farm = GREEN;
        tick();
        light_farm = RED;
        vectors++;
        if (sensor !== 2'b01) begin errors++; $display("FAIL clear_edge1 got=%b exp=%b", sensor, 2'b01); end
        tick();
        vectors++;
        if (sensor !== 2'b00) begin errors++; $display("FAIL clear_edge2 got=%b exp=%b", sensor, 2'b00); end
    endtask

    task automatic test_collision();
        do_reset();
        raw_det = 2'b10;
        for (int j = 0; j < 5; j++) tick();
        // Green present at edge k+5, the same edge the debounced level rises.
        light_highway = GREEN;
        tick();
        light_highway = RED;
        tick();
        vectors++;
        if (sensor !== 2'b10) begin errors++; $display("FAIL collide_k6 got=%b exp=%b", sensor, 2'b10); end
        raw_det = 2'b00;
        for (int j = 0; j < 12; j++) tick();
        vectors++;
        if (sensor !== 2'b10) begin errors++; $display("FAIL collide_req_kept got=%b exp=%b", sensor, 2'b10); end
        light_highway = GREEN;
        tick();
        light_highway = RED;
        tick();
        vectors++;
        if (sensor !== 2'b00) begin errors++; $display("FAIL collide_then_clear got=%b exp=%b", sensor, 2'b00); end
    endtask

    task automatic test_stuck();
        do_reset();
        raw_det = 2'b01;
        // Debounced high from edge k+5; 16 counted edges put stuck at edge k+21 (j=22).
        for (int j = 1; j <= 30; j++) begin
            light_farm = (j % 2 == 1) ? GREEN : RED;
            tick();
            if (j == 21) begin
                vectors++;
                if (stuck !== 2'b00) begin errors++; $display("FAIL stuck_early got=%b exp=%b", stuck, 2'b00); end
            end
            if (j == 22) begin
                vectors++;
                if (stuck !== 2'b01) begin errors++; $display("FAIL stuck_set got=%b exp=%b", stuck, 2'b01); end
            end
        end
        raw_det    = 2'b00;
        light_farm = GREEN;
        for (int j = 0; j < 12; j++) tick();
        vectors++;
        if (sensor !== 2'b01) begin errors++; $display("FAIL stuck_forces_sensor got=%b exp=%b", sensor, 2'b01); end
        vectors++;
        if (stuck !== 2'b01) begin errors++; $display("FAIL stuck_sticky got=%b exp=%b", stuck, 2'b01); end
        rst_n = 1'b0;
        tick();
        rst_n      = 1'b1;
        light_farm = RED;
        vectors++;
        if (sensor !== 2'b00) begin errors++; $display("FAIL stuck_reset_sensor got=%b exp=%b", sensor, 2'b00); end
        vectors++;
        if (stuck !== 2'b00) begin errors++; $display("FAIL stuck_reset_flag got=%b exp=%b", stuck, 2'b00); end
        for (int j = 0; j < 4; j++) tick();
        vectors++;
        if (sensor !== 2'b00) begin errors++; $display("FAIL stuck_post_reset got=%b exp=%b", sensor, 2'b00); end
    endtask

    task automatic test_both_channels();
        logic [1:0] seq [4];
        logic [1:0] exp_end [4];
        seq     = '{2'b10, 2'b01, 2'b11, 2'b00};
        exp_end = '{2'b10, 2'b11, 2'b11, 2'b11};
        do_reset();
        for (int p = 0; p < 4; p++) begin
            raw_det = seq[p];
            for (int j = 0; j < 8; j++) tick();
            vectors++;
            if (sensor !== exp_end[p]) begin
                errors++; $display("FAIL both_phase%0d got=%b exp=%b", p, sensor, exp_end[p]);
            end
        end
        for (int j = 0; j < 8; j++) tick();
        vectors++;
        if (sensor !== 2'b11) begin errors++; $display("FAIL both_latched got=%b exp=%b", sensor, 2'b11); end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_req_hold_clear();
        test_collision();
        test_stuck();
        test_both_channels();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
